// File: rtl/pwm_ramp_controller.sv
// PWM period counter with soft-start duty ramping toward one of a fixed set of levels.
// Duty only moves at the period boundary, so a period never sees two compare values.
module pwm_ramp_controller #(
    parameter int PERIOD     = 100,
    parameter int LEVEL_STEP = 25,
    parameter int NUM_LEVELS = 5,
    parameter int RAMP_STEP  = 5
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iUp,
    input  logic       iDown,
    input  logic       iEnable,
    output logic [7:0] oDuty,
    output logic       oPWM,
    output logic       oPeriodStart,
    output logic       oBusy,
    output logic [2:0] oLevel
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        HOLD
    } state_t;

    localparam logic [7:0] PERIOD_C     = 8'(PERIOD);
    localparam logic [7:0] LEVEL_STEP_C = 8'(LEVEL_STEP);
    localparam logic [7:0] RAMP_STEP_C  = 8'(RAMP_STEP);
    localparam logic [2:0] MAX_INDEX    = 3'(NUM_LEVELS - 1);

    logic [7:0] counter_q, counter_d;
    logic [2:0] index_q, index_d;
    logic [7:0] duty_q, duty_d;
    logic       pwm_q, pwm_d;
    state_t     state_q, state_d;

    logic [7:0] target;
    logic [7:0] gap;
    logic       boundary;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            counter_q <= 8'd0;
            index_q   <= 3'd0;
            duty_q    <= 8'd0;
            pwm_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            counter_q <= counter_d;
            index_q   <= index_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        boundary  = (counter_q == PERIOD_C);
        counter_d = boundary ? 8'd0 : counter_q + 8'd1;

        index_d = index_q;
        if (iUp && !iDown && index_q != MAX_INDEX) begin
            index_d = index_q + 3'd1;
        end else if (iDown && !iUp && index_q != 3'd0) begin
            index_d = index_q - 3'd1;
        end

        // Disabling only zeroes the target; the selected index is kept for resume.
        target = iEnable ? 8'(index_q) * LEVEL_STEP_C : 8'd0;

        gap    = 8'd0;
        duty_d = duty_q;
        if (boundary) begin
            if (duty_q < target) begin
                gap    = target - duty_q;
                duty_d = duty_q + ((gap < RAMP_STEP_C) ? gap : RAMP_STEP_C);
            end else if (duty_q > target) begin
                gap    = duty_q - target;
                duty_d = duty_q - ((gap < RAMP_STEP_C) ? gap : RAMP_STEP_C);
            end
        end

        pwm_d = (counter_q < duty_q);
    end

    // State tracks the relation of applied duty to the live target every cycle.
    always_comb begin
        state_d = state_q;
        if (duty_q < target) begin
            state_d = RAMP_UP;
        end else if (duty_q > target) begin
            state_d = RAMP_DOWN;
        end else if (duty_q == 8'd0) begin
            state_d = IDLE;
        end else begin
            state_d = HOLD;
        end
    end

    assign oDuty        = duty_q;
    assign oPWM         = pwm_q;
    assign oPeriodStart = (counter_q == 8'd0);
    assign oBusy        = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    assign oLevel       = index_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Scenario bench for pwm_ramp_controller: expected duty per period is queued up front
// and popped at every period start.
module tb_pwm_ramp_controller;

    logic       iClk;
    logic       iReset;
    logic       iUp;
    logic       iDown;
    logic       iEnable;
    logic [7:0] oDuty;
    logic       oPWM;
    logic       oPeriodStart;
    logic       oBusy;
    logic [2:0] oLevel;

    int          cyc;
    int          n_compared;
    int          n_mismatched;
    int          high_cnt;
    logic [7:0]  exp_duty;
    logic [7:0]  exp_duty_q[$];

    pwm_ramp_controller dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iUp         (iUp),
        .iDown       (iDown),
        .iEnable     (iEnable),
        .oDuty       (oDuty),
        .oPWM        (oPWM),
        .oPeriodStart(oPeriodStart),
        .oBusy       (oBusy),
        .oLevel      (oLevel)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
        cyc++;
    endtask

    // Leaves the bench at cycle 0: the first cycle after reset, counter at 0.
    task automatic do_reset();
        iReset  = 1'b1;
        iUp     = 1'b0;
        iDown   = 1'b0;
        iEnable = 1'b1;
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        cyc    = 0;
        exp_duty_q.delete();
    endtask

    task automatic pulse_up();
        iUp = 1'b1;
        tick();
        iUp = 1'b0;
        tick();
    endtask

    task automatic pulse_down();
        iDown = 1'b1;
        tick();
        iDown = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if (oLevel !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_level: got %0d expected 0", oLevel); end
        while (cyc < 303) begin
            n_compared++;
            if (oPeriodStart !== (cyc % 101 == 0)) begin
                n_mismatched++; $display("[TB] FAIL reset_pstart cyc %0d: got %0b expected %0b", cyc, oPeriodStart, (cyc % 101 == 0));
            end
            n_compared++;
            if (oDuty !== 8'd0 || oPWM !== 1'b0 || oBusy !== 1'b0) begin
                n_mismatched++; $display("[TB] FAIL reset_idle cyc %0d: duty %0d pwm %0b busy %0b expected 0/0/0", cyc, oDuty, oPWM, oBusy);
            end
            tick();
        end
    endtask

    task automatic test_single_up();
        do_reset();
        while (cyc < 10) tick();
        iUp = 1'b1;
        tick();
        iUp = 1'b0;
        n_compared++;
        if (oLevel !== 3'd1 || oBusy !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL up_level_c11: level %0d busy %0b expected 1/0", oLevel, oBusy);
        end
        tick();
        n_compared++;
        if (oBusy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL up_busy_c12: got %0b expected 1", oBusy); end
        for (int k = 1; k <= 5; k++) exp_duty_q.push_back(8'(5 * k));
        exp_duty_q.push_back(8'd25);
        high_cnt = 0;
        while (cyc < 606) begin
            tick();
            if (oPeriodStart) begin
                n_compared++;
                if (exp_duty_q.size() == 0) begin
                    n_mismatched++; $display("[TB] FAIL up_sb_underrun cyc %0d: got %0d expected none", cyc, oDuty);
                end else begin
                    exp_duty = exp_duty_q.pop_front();
                    if (oDuty !== exp_duty) begin n_mismatched++; $display("[TB] FAIL up_duty cyc %0d: got %0d expected %0d", cyc, oDuty, exp_duty); end
                end
            end
            if (cyc == 505) begin
                n_compared++;
                if (oBusy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL up_busy_c505: got %0b expected 1", oBusy); end
            end
            if (cyc == 506) begin
                n_compared++;
                if (oBusy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL up_busy_c506: got %0b expected 0", oBusy); end
            end
            if (cyc >= 506 && oPWM) high_cnt++;
        end
        n_compared++;
        if (exp_duty_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL up_sb_left: got %0d entries expected 0", exp_duty_q.size()); end
        n_compared++;
        if (high_cnt != 25) begin n_mismatched++; $display("[TB] FAIL up_pwm_high: got %0d expected 25", high_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int p = 0; p < 6; p++) pulse_up();
        n_compared++;
        if (oLevel !== 3'd4) begin n_mismatched++; $display("[TB] FAIL sat_level: got %0d expected 4", oLevel); end
        for (int k = 1; k <= 20; k++) exp_duty_q.push_back(8'(5 * k));
        high_cnt = 0;
        while (cyc < 2121) begin
            tick();
            if (oPeriodStart && exp_duty_q.size() != 0) begin
                exp_duty = exp_duty_q.pop_front();
                n_compared++;
                if (oDuty !== exp_duty) begin n_mismatched++; $display("[TB] FAIL sat_duty cyc %0d: got %0d expected %0d", cyc, oDuty, exp_duty); end
            end
            if (cyc >= 2021 && oPWM) high_cnt++;
        end
        n_compared++;
        if (exp_duty_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL sat_sb_left: got %0d entries expected 0", exp_duty_q.size()); end
        n_compared++;
        if (high_cnt != 100) begin n_mismatched++; $display("[TB] FAIL sat_pwm_high: got %0d expected 100", high_cnt); end
        n_compared++;
        if (oDuty !== 8'd100 || oBusy !== 1'b0 || oLevel !== 3'd4) begin
            n_mismatched++; $display("[TB] FAIL sat_hold: duty %0d busy %0b level %0d expected 100/0/4", oDuty, oBusy, oLevel);
        end
    endtask

    task automatic test_both_pressed();
        do_reset();
        pulse_up();
        pulse_up();
        for (int k = 1; k <= 10; k++) exp_duty_q.push_back(8'(5 * k));
        while (cyc < 1015) begin
            tick();
            if (oPeriodStart && exp_duty_q.size() != 0) begin
                exp_duty = exp_duty_q.pop_front();
                n_compared++;
                if (oDuty !== exp_duty) begin n_mismatched++; $display("[TB] FAIL both_ramp cyc %0d: got %0d expected %0d", cyc, oDuty, exp_duty); end
            end
        end
        iUp   = 1'b1;
        iDown = 1'b1;
        tick();
        iUp   = 1'b0;
        iDown = 1'b0;
        n_compared++;
        if (oLevel !== 3'd2) begin n_mismatched++; $display("[TB] FAIL both_level: got %0d expected 2", oLevel); end
        while (cyc < 1112) begin
            tick();
            n_compared++;
            if (oDuty !== 8'd50 || oBusy !== 1'b0) begin
                n_mismatched++; $display("[TB] FAIL both_hold cyc %0d: duty %0d busy %0b expected 50/0", cyc, oDuty, oBusy);
            end
        end
        for (int p = 0; p < 4; p++) pulse_down();
        n_compared++;
        if (oLevel !== 3'd0) begin n_mismatched++; $display("[TB] FAIL down_sat_level: got %0d expected 0", oLevel); end
    endtask

    task automatic test_reversal();
        do_reset();
        pulse_up();
        iUp = 1'b1;
        tick();
        iUp = 1'b0;
        foreach (exp_duty_q[i]) exp_duty_q.delete(i);
        exp_duty_q = '{8'd5, 8'd10, 8'd15, 8'd10, 8'd5, 8'd0, 8'd0};
        while (cyc < 707) begin
            tick();
            if (cyc == 310 || cyc == 312) iDown = 1'b1;
            if (cyc == 311 || cyc == 313) iDown = 1'b0;
            if (oPeriodStart && exp_duty_q.size() != 0) begin
                exp_duty = exp_duty_q.pop_front();
                n_compared++;
                if (oDuty !== exp_duty) begin n_mismatched++; $display("[TB] FAIL rev_duty cyc %0d: got %0d expected %0d", cyc, oDuty, exp_duty); end
            end
            if (cyc == 314) begin
                n_compared++;
                if (oLevel !== 3'd0) begin n_mismatched++; $display("[TB] FAIL rev_level: got %0d expected 0", oLevel); end
            end
            if (cyc == 400 || cyc == 550) begin
                n_compared++;
                if (oBusy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rev_busy cyc %0d: got %0b expected 1", cyc, oBusy); end
            end
            if (cyc == 607 || cyc == 706) begin
                n_compared++;
                if (oBusy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rev_idle cyc %0d: got %0b expected 0", cyc, oBusy); end
            end
        end
        n_compared++;
        if (exp_duty_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL rev_sb_left: got %0d entries expected 0", exp_duty_q.size()); end
    endtask

    task automatic test_enable_pause();
        do_reset();
        for (int p = 0; p < 3; p++) pulse_up();
        for (int k = 1; k <= 15; k++) exp_duty_q.push_back(8'(5 * k));
        for (int k = 1; k <= 8; k++) exp_duty_q.push_back(8'(75 - 5 * k));
        for (int k = 1; k <= 8; k++) exp_duty_q.push_back(8'(35 + 5 * k));
        while (cyc < 3133) begin
            tick();
            if (cyc == 1520) begin
                n_compared++;
                if (oBusy !== 1'b0 || oDuty !== 8'd75) begin
                    n_mismatched++; $display("[TB] FAIL en_hold75: duty %0d busy %0b expected 75/0", oDuty, oBusy);
                end
                iEnable = 1'b0;
            end
            if (cyc == 2324) iEnable = 1'b1;
            if (oPeriodStart) begin
                n_compared++;
                if (oLevel !== 3'd3) begin n_mismatched++; $display("[TB] FAIL en_level cyc %0d: got %0d expected 3", cyc, oLevel); end
                if (exp_duty_q.size() != 0) begin
                    exp_duty = exp_duty_q.pop_front();
                    n_compared++;
                    if (oDuty !== exp_duty) begin n_mismatched++; $display("[TB] FAIL en_duty cyc %0d: got %0d expected %0d", cyc, oDuty, exp_duty); end
                end
            end
        end
        n_compared++;
        if (exp_duty_q.size() != 0 || oBusy !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL en_end: left %0d busy %0b expected 0/0", exp_duty_q.size(), oBusy);
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        pulse_up();
        pulse_up();
        for (int k = 1; k <= 8; k++) exp_duty_q.push_back(8'(5 * k));
        while (cyc < 850) begin
            tick();
            if (oPeriodStart && exp_duty_q.size() != 0) begin
                exp_duty = exp_duty_q.pop_front();
                n_compared++;
                if (oDuty !== exp_duty) begin n_mismatched++; $display("[TB] FAIL rst_ramp cyc %0d: got %0d expected %0d", cyc, oDuty, exp_duty); end
            end
        end
        n_compared++;
        if (oDuty !== 8'd40 || oBusy !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL rst_pre: duty %0d busy %0b expected 40/1", oDuty, oBusy);
        end
        iReset = 1'b1;
        tick();
        n_compared++;
        if (oDuty !== 8'd0 || oPWM !== 1'b0 || oBusy !== 1'b0 || oLevel !== 3'd0 || oPeriodStart !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_mid: duty %0d pwm %0b busy %0b level %0d pstart %0b expected 0/0/0/0/1",
                     oDuty, oPWM, oBusy, oLevel, oPeriodStart);
        end
        iReset = 1'b0;
        cyc    = 0;
        iUp    = 1'b1;
        tick();
        iUp = 1'b0;
        while (cyc < 101) tick();
        n_compared++;
        if (oDuty !== 8'd5 || oLevel !== 3'd1) begin
            n_mismatched++; $display("[TB] FAIL rst_restart: duty %0d level %0d expected 5/1", oDuty, oLevel);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        iReset       = 1'b1;
        iUp          = 1'b0;
        iDown        = 1'b0;
        iEnable      = 1'b1;
        test_reset();
        test_single_up();
        test_saturate();
        test_both_pressed();
        test_reversal();
        test_enable_pause();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
